// File: rtl/gf180mcu_fd_sc_mcu7t5v0__ret_pkg.sv
// Shared definitions for the retention power sequencer: state encoding,
// default timing constants and the Moore output decode for each state.
package gf180mcu_fd_sc_mcu7t5v0__ret_pkg;

    // Default isolation setup/hold length and power-good timeout, in cycles.
    localparam int RET_ISO_CYC_DEF = 2;
    localparam int RET_TO_CYC_DEF  = 64;

    // Sequencer states; the numeric values are visible on the STATE port.
    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_ISO_ON  = 3'd1,
        ST_SAV     = 3'd2,
        ST_PWR_DN  = 3'd3,
        ST_OFF     = 3'd4,
        ST_PWR_UP  = 3'd5,
        ST_RST_R   = 3'd6,
        ST_ISO_OFF = 3'd7
    } ret_state_t;

    // Control outputs driven towards the switchable domain.
    typedef struct packed {
        logic iso;
        logic save;
        logic restore;
        logic pwr_en;
        logic ack;
    } ret_out_t;

    // Output pattern for each state. ISO stays high in every state where the
    // header switch is open, and the save/restore strobes live in separate
    // single-cycle states so they can never overlap.
    function automatic ret_out_t ret_decode(input ret_state_t st);
        ret_out_t o;
        o = '{iso: 1'b1, save: 1'b0, restore: 1'b0, pwr_en: 1'b1, ack: 1'b0};
        case (st)
            ST_ON:      o.iso = 1'b0;
            ST_ISO_ON:  o.iso = 1'b1;
            ST_SAV:     o.save = 1'b1;
            ST_PWR_DN:  o.pwr_en = 1'b0;
            ST_OFF: begin
                o.pwr_en = 1'b0;
                o.ack    = 1'b1;
            end
            ST_PWR_UP:  o.ack = 1'b1;
            ST_RST_R: begin
                o.restore = 1'b1;
                o.ack     = 1'b1;
            end
            ST_ISO_OFF: o.ack = 1'b1;
            default:    o.iso = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__ret_cnt.sv
// Saturating dwell counter for the retention sequencer. Cleared on every
// state entry; tc flags that the count equals the supplied terminal value.
module gf180mcu_fd_sc_mcu7t5v0__ret_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt_reg;

    // Count cycles spent in the current state, holding at all-ones.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign tc = (cnt_reg == tc_val);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__ret_seq.sv
// Retention power-down/up sequencer with a four-phase REQ/ACK handshake.
// Sleep: isolate, save, open header, wait for power to drop, acknowledge.
// Wake: close header, wait for power good, restore, release isolation.
// Optional macro GF180MCU_FD_SC_MCU7T5V0__RET_TIMEOUT_EN adds a power-good
// timeout that raises sticky ERR and advances anyway; without it the
// sequencer waits for PWR_OK indefinitely and ERR is tied low.
module gf180mcu_fd_sc_mcu7t5v0__ret_seq
    import gf180mcu_fd_sc_mcu7t5v0__ret_pkg::*;
#(
    parameter int ISO_CYC = RET_ISO_CYC_DEF,
    parameter int TO_CYC  = RET_TO_CYC_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ,
    input  logic       PWR_OK,
    output logic       ACK,
    output logic       ISO,
    output logic       SAVE,
    output logic       RESTORE,
    output logic       PWR_EN,
    output logic [2:0] STATE,
    output logic       ERR
);

    localparam int CW = $clog2(TO_CYC + 1);
    // Dwell counter starts at 0 on entry, so the last cycle sees N-1.
    localparam logic [CW-1:0] ISO_TC = CW'(ISO_CYC - 1);

    ret_state_t    state_reg;
    ret_state_t    state_next;
    ret_out_t      out_reg;
    logic          cnt_clr;
    logic          cnt_tc;
    logic [CW-1:0] tc_val;

`ifdef GF180MCU_FD_SC_MCU7T5V0__RET_TIMEOUT_EN
    localparam logic [CW-1:0] TO_TC = CW'(TO_CYC - 1);
    logic err_reg;
    logic err_set;

    // The power-wait states compare against the timeout, the rest against ISO_CYC.
    assign tc_val = ((state_reg == ST_PWR_DN) || (state_reg == ST_PWR_UP)) ? TO_TC : ISO_TC;
`else
    assign tc_val = ISO_TC;
`endif

    // A state change restarts the dwell count for the state being entered.
    assign cnt_clr = (state_next != state_reg);

    gf180mcu_fd_sc_mcu7t5v0__ret_cnt #(
        .W (CW)
    ) u_cnt (
        .clk    (CLK),
        .srst   (RST),
        .clr    (cnt_clr),
        .en     (1'b1),
        .tc_val (tc_val),
        .tc     (cnt_tc)
    );

    // Next-state logic; once started, a sleep or wake sequence always completes.
    always_comb begin
        state_next = state_reg;
`ifdef GF180MCU_FD_SC_MCU7T5V0__RET_TIMEOUT_EN
        err_set = 1'b0;
`endif
        case (state_reg)
            ST_ON:      if (REQ) state_next = ST_ISO_ON;
            ST_ISO_ON:  if (cnt_tc) state_next = ST_SAV;
            ST_SAV:     state_next = ST_PWR_DN;
            ST_PWR_DN: begin
                if (!PWR_OK) begin
                    state_next = ST_OFF;
                end
`ifdef GF180MCU_FD_SC_MCU7T5V0__RET_TIMEOUT_EN
                else if (cnt_tc) begin
                    state_next = ST_OFF;
                    err_set    = 1'b1;
                end
`endif
            end
            ST_OFF:     if (!REQ) state_next = ST_PWR_UP;
            ST_PWR_UP: begin
                if (PWR_OK) begin
                    state_next = ST_RST_R;
                end
`ifdef GF180MCU_FD_SC_MCU7T5V0__RET_TIMEOUT_EN
                else if (cnt_tc) begin
                    state_next = ST_RST_R;
                    err_set    = 1'b1;
                end
`endif
            end
            ST_RST_R:   state_next = ST_ISO_OFF;
            ST_ISO_OFF: if (cnt_tc) state_next = ST_ON;
            default:    state_next = ST_ON;
        endcase
    end

    // State and output registers; outputs are decoded from the next state so
    // they change on the same edge as STATE and never see an input directly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_ON;
            out_reg   <= ret_decode(ST_ON);
        end else begin
            state_reg <= state_next;
            out_reg   <= ret_decode(state_next);
        end
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0__RET_TIMEOUT_EN
    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_reg <= 1'b0;
        end else if (err_set) begin
            err_reg <= 1'b1;
        end
    end

    assign ERR = err_reg;
`else
    assign ERR = 1'b0;
`endif

    assign STATE   = state_reg;
    assign ISO     = out_reg.iso;
    assign SAVE    = out_reg.save;
    assign RESTORE = out_reg.restore;
    assign PWR_EN  = out_reg.pwr_en;
    assign ACK     = out_reg.ack;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__ret_seq.sv
// Self-checking bench for the retention sequencer: a table of directed
// vectors, hand-written multi-cycle corner cases and a randomized run
// against a behavioural model. Works with or without
// GF180MCU_FD_SC_MCU7T5V0__RET_TIMEOUT_EN.
module tb_gf180mcu_fd_sc_mcu7t5v0__ret_seq;

    localparam int ISO_CYC = 2;
    localparam int TO_CYC  = 8;
`ifdef GF180MCU_FD_SC_MCU7T5V0__RET_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       CLK;
    logic       RST;
    logic       REQ;
    logic       PWR_OK;
    logic       ACK;
    logic       ISO;
    logic       SAVE;
    logic       RESTORE;
    logic       PWR_EN;
    logic [2:0] STATE;
    logic       ERR;

    gf180mcu_fd_sc_mcu7t5v0__ret_seq #(
        .ISO_CYC (ISO_CYC),
        .TO_CYC  (TO_CYC)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .PWR_OK  (PWR_OK),
        .ACK     (ACK),
        .ISO     (ISO),
        .SAVE    (SAVE),
        .RESTORE (RESTORE),
        .PWR_EN  (PWR_EN),
        .STATE   (STATE),
        .ERR     (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: state number, cycles left in a timed isolation
    // phase, cycles spent waiting for power, sticky error.
    int m_state = 0;
    int m_left  = 0;
    int m_wait  = 0;
    bit m_err   = 1'b0;
    bit prev_save = 1'b0;
    bit prev_restore = 1'b0;

    typedef struct {
        logic       rst;
        logic       req;
        logic       pok;
        logic [8:0] exp;   // {state, iso, save, restore, pwr_en, ack, err}
    } vec_t;
    vec_t tbl[$];

    // Expected outputs of a state, straight from the state table.
    function automatic logic [8:0] spec_out(input int st, input bit err);
        logic iso, sv, rs, pw, ak;
        iso = (st != 0);
        sv  = (st == 2);
        rs  = (st == 6);
        pw  = !((st == 3) || (st == 4));
        ak  = (st >= 4);
        return {3'(st), iso, sv, rs, pw, ak, err};
    endfunction

    function automatic logic [8:0] dut_out();
        return {STATE, ISO, SAVE, RESTORE, PWR_EN, ACK, ERR};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d iso,save,restore,pwr_en,ack,err=%b required state=%0d %b",
                     name, act[8:6], act[5:0], exp[8:6], exp[5:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic model_enter(input int s);
        m_state = s;
        m_left  = ISO_CYC;
        m_wait  = 0;
    endtask

    // Advance the model by one clock edge with the sampled inputs.
    task automatic model_update(input logic r, input logic q, input logic p);
        if (r) begin
            model_enter(0);
            m_err = 1'b0;
        end else begin
            case (m_state)
                0: if (q) model_enter(1);
                1: begin
                    m_left--;
                    if (m_left == 0) model_enter(2);
                end
                2: model_enter(3);
                3: begin
                    m_wait++;
                    if (!p) model_enter(4);
                    else if (TMO_EN && m_wait >= TO_CYC) begin
                        m_err = 1'b1;
                        model_enter(4);
                    end
                end
                4: if (!q) model_enter(5);
                5: begin
                    m_wait++;
                    if (p) model_enter(6);
                    else if (TMO_EN && m_wait >= TO_CYC) begin
                        m_err = 1'b1;
                        model_enter(6);
                    end
                end
                6: model_enter(7);
                default: begin
                    m_left--;
                    if (m_left == 0) model_enter(0);
                end
            endcase
        end
    endtask

    // One clock: drive inputs, update the model at the edge, check the
    // always-true properties 1 time unit after the edge.
    task automatic step(input logic r, input logic q, input logic p);
        RST = r;
        REQ = q;
        PWR_OK = p;
        @(posedge CLK);
        model_update(r, q, p);
        #1;
        checks++;
        if (!(ISO === 1'b1 || PWR_EN === 1'b1)) begin
            errors++;
            $display("FAIL iso_when_off: got iso=%b pwr_en=%b required iso=1", ISO, PWR_EN);
        end
        checks++;
        if (SAVE === 1'b1 && RESTORE === 1'b1) begin
            errors++;
            $display("FAIL save_restore_overlap: got save=1 restore=1 required not both");
        end
        checks++;
        if (SAVE === 1'b1 && prev_save) begin
            errors++;
            $display("FAIL save_width: got save high two cycles required one");
        end
        checks++;
        if (RESTORE === 1'b1 && prev_restore) begin
            errors++;
            $display("FAIL restore_width: got restore high two cycles required one");
        end
        prev_save    = (SAVE === 1'b1);
        prev_restore = (RESTORE === 1'b1);
    endtask

    task automatic add(input logic r, input logic q, input logic p, input logic [8:0] e, input int n);
        vec_t v;
        v.rst = r;
        v.req = q;
        v.pok = p;
        v.exp = e;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        logic [23:0] seq;
        int nseq, nsave, nrest, prev_st;
        bit done;
        logic pok_sw, rq, rp, rr;

        RST = 1'b1;
        REQ = 1'b0;
        PWR_OK = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Reset, full sleep with PWR_OK dropping 3 cycles after PWR_EN=0,
        // then wake with PWR_OK rising 5 cycles after REQ falls.
        add(1, 0, 1, 9'b000_000100, 1);
        add(0, 1, 1, 9'b001_100100, 2);
        add(0, 1, 1, 9'b010_110100, 1);
        add(0, 1, 1, 9'b011_100000, 4);
        add(0, 1, 0, 9'b100_100010, 1);
        add(0, 0, 0, 9'b101_100110, 6);
        add(0, 0, 1, 9'b110_101110, 1);
        add(0, 0, 1, 9'b111_100110, 2);
        add(0, 0, 1, 9'b000_000100, 1);
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].pok);
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // One-cycle REQ pulse: full sleep then full wake, each state once.
        seq = '0;
        nseq = 0;
        nsave = 0;
        nrest = 0;
        prev_st = 0;
        done = 1'b0;
        pok_sw = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            pok_sw = PWR_EN;
            step(1'b0, (k == 0), pok_sw);
            check("pulse_model", dut_out(), spec_out(m_state, m_err));
            if (SAVE === 1'b1) nsave++;
            if (RESTORE === 1'b1) nrest++;
            if (int'(STATE) != prev_st) begin
                seq = {seq[20:0], STATE};
                nseq++;
                prev_st = int'(STATE);
                if (STATE == 3'd0) done = 1'b1;
            end
        end
        check_int("pulse_done", int'(done), 1);
        check_int("pulse_seq", int'(seq), int'(24'o12345670));
        check_int("pulse_nstates", nseq, 8);
        check_int("pulse_saves", nsave, 1);
        check_int("pulse_restores", nrest, 1);

        // Reset while waiting in PWR_DN returns straight to ON.
        repeat (4) step(1'b0, 1'b1, 1'b1);
        check("pre_rst_pwr_dn", dut_out(), 9'b011_100000);
        step(1'b1, 1'b1, 1'b0);
        check("rst_in_pwr_dn", dut_out(), 9'b000_000100);
        step(1'b0, 1'b0, 1'b1);

        // PWR_OK stuck high in PWR_DN: timeout after TO_CYC cycles if enabled.
        step(1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b1);
        check("to_enter", dut_out(), 9'b011_100000);
        repeat (TO_CYC - 1) step(1'b0, 1'b1, 1'b1);
        check("to_edge", dut_out(), 9'b011_100000);
        step(1'b0, 1'b1, 1'b1);
        check("to_fire", dut_out(), TMO_EN ? 9'b100_100011 : 9'b011_100000);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        check("to_sticky", dut_out(), TMO_EN ? 9'b100_100011 : 9'b011_100000);
        step(1'b1, 1'b0, 1'b1);
        check("to_rst_clear", dut_out(), 9'b000_000100);

        // Randomized run against the model.
        rq = 1'b0;
        rp = 1'b1;
        for (int n = 0; n < 600; n++) begin
            rr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 11) == 0) rq = ~rq;
            if ($urandom_range(0, 5) == 0) rp = ~rp;
            step(rr, rq, rp);
            check("rand", dut_out(), spec_out(m_state, m_err));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__ret_seq.md
GF180MCU_FD_SC_MCU7T5V0__RET_SEQ -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__ret_seq

Interface
REQ-001 SHALL have parameter ISO_CYC, default 2, meaning isolation setup/hold cycles (legal range 1..15).
REQ-002 SHALL have parameter TO_CYC, default 64, meaning the power-good timeout in cycles (legal range 2..1023).
REQ-003 SHALL have port CLK, input, 1, the single rising-edge clock.
REQ-004 SHALL have port RST, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port REQ, input, 1, the retention request level (1 = sleep, 0 = awake).
REQ-006 SHALL have port PWR_OK, input, 1, power-switch status (1 = domain powered); it is pre-synchronised.
REQ-007 SHALL have port ACK, output, 1, the four-phase acknowledge (1 = domain off and retained).
REQ-008 SHALL have port ISO, output, 1, the isolation-cell enable.
REQ-009 SHALL have port SAVE, output, 1, the retention-flop save strobe.
REQ-010 SHALL have port RESTORE, output, 1, the retention-flop restore strobe.
REQ-011 SHALL have port PWR_EN, output, 1, the header-switch enable.
REQ-012 SHALL have port STATE, output, 3, the current FSM encoding.
REQ-013 SHALL have port ERR, output, 1, a sticky timeout flag.

Function
REQ-014 SHALL implement the FSM states ON=0, ISO_ON=1, SAV=2, PWR_DN=3, OFF=4, PWR_UP=5, RST_R=6, ISO_OFF=7; STATE equals the registered state.
REQ-015 SHALL make all outputs registered Moore outputs with no combinational path from an input to an output.
REQ-016 ON: ISO=0, PWR_EN=1, ACK=0; on REQ=1, SHALL go to ISO_ON next cycle.
REQ-017 ISO_ON: ISO=1; SHALL hold for exactly ISO_CYC cycles, then go to SAV.
REQ-018 SAV: SAVE=1 for exactly one cycle; SHALL then go to PWR_DN.
REQ-019 PWR_DN: PWR_EN=0, ISO=1; SHALL go to OFF on the first cycle PWR_OK=0 is sampled.
REQ-020 OFF: ACK=1, PWR_EN=0, ISO=1; on REQ=0, SHALL go to PWR_UP.
REQ-021 PWR_UP: PWR_EN=1, ACK=1; SHALL go to RST_R on the first cycle PWR_OK=1 is sampled.
REQ-022 RST_R: RESTORE=1 for exactly one cycle; SHALL then go to ISO_OFF.
REQ-023 ISO_OFF: ISO=1 for ISO_CYC cycles; SHALL then go to ON, where ACK falls and ISO falls in the same cycle.
REQ-024 SHALL never abort a sequence: if REQ drops before OFF, the sleep sequence completes to OFF and the wake sequence starts on the following cycle; a REQ pulse in a wake state likewise completes to ON first.
REQ-025 SHALL never assert SAVE and RESTORE together, and SHALL keep ISO=1 whenever PWR_EN=0.
REQ-026 SHALL use a cycle counter of width $clog2(TO_CYC+1), cleared on every state entry and saturating at its maximum.

Reset
REQ-027 When RST=1 at a clock edge, the outputs SHALL be: STATE=ON, ISO=0, SAVE=0, RESTORE=0, PWR_EN=1, ACK=0, ERR=0, counter=0.
REQ-028 Reset in any state, including mid-PWR_DN or OFF, SHALL force ON immediately; retained data is not restored, and that is accepted.
REQ-029 REQ and PWR_OK SHALL be ignored in the cycle RST=1.

Configuration
REQ-030 With GF180MCU_FD_SC_MCU7T5V0__RET_TIMEOUT_EN defined, if PWR_DN or PWR_UP lasts TO_CYC cycles without the awaited PWR_OK level, the block SHALL set ERR=1 (sticky until RST) and advance as if PWR_OK had arrived.
REQ-031 With the macro undefined, ERR SHALL be tied 0, PWR_DN/PWR_UP SHALL wait indefinitely, and no timeout logic SHALL be present.

Structure
REQ-032 SHALL place the state enum (3-bit) and the ISO_CYC/TO_CYC default constants in the shared package gf180mcu_fd_sc_mcu7t5v0__ret_pkg.
REQ-033 SHALL place the counter in a sub-module gf180mcu_fd_sc_mcu7t5v0__ret_cnt (clear, enable, saturating, terminal-count compare); the FSM stays in the top.

Verification
REQ-034 Reset, then REQ=1 at cycle 0 with PWR_OK dropping 3 cycles after PWR_EN=0 -> ISO=1 at cycle 1, SAVE pulse at cycle 3, PWR_EN=0 at cycle 4, ACK=1 at cycle 8.
REQ-035 From OFF, REQ=0 with PWR_OK rising 5 cycles later -> PWR_EN=1 next cycle, RESTORE one cycle after PWR_OK is sampled, ACK=0 and ISO=0 ISO_CYC cycles later, STATE=0.
REQ-036 REQ=1 for 1 cycle only -> the full sleep sequence reaches OFF, then wakes back to ON with no skipped state and SAVE/RESTORE each pulsed once.
REQ-037 RST=1 asserted during PWR_DN -> next cycle STATE=0, PWR_EN=1, ISO=0, ACK=0.
REQ-038 With the macro defined and TO_CYC=8, PWR_OK held 1 in PWR_DN -> ERR=1 after 8 cycles, then OFF; without the macro -> stays in PWR_DN and ERR=0.
REQ-039 The assertion bench SHALL check across all tests: ISO=1 whenever PWR_EN=0; SAVE and RESTORE never both 1; SAVE and RESTORE each at most one cycle wide.
